// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the 4x4 keypad entry block:
//               FSM state encoding, row count and the row/column keymap.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_RELEASE  = 2'd2
  } state_t;

  // KEYMAP[row][col]; each 16-bit slice holds one row, col0 in the low nibble.
  //   r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = E(*) 0 F(#) D
  localparam logic [3:0][3:0][3:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  // Index of the lowest active-low column; 0 when none is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] cols_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
// Module      : keypad_sync
// Description : 4-bit two-flop synchronizer for the active-low column lines.
//               Resets to all ones so a reset never looks like a key press.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d_n,
  output logic [3:0] q_n
);

  logic [3:0] meta_n;

  // Two back-to-back flops bring the asynchronous columns into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_n <= 4'hF;
      q_n    <= 4'hF;
    end else begin
      meta_n <= d_n;
      q_n    <= meta_n;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry
// Description : 4x4 matrix keypad scanner with debounce, single-shot key
//               acceptance and an 8-digit hex entry shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  col_n,
  input  logic        clear,
  output logic [3:0]  row_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] value,
  output logic [3:0]  digit_count
);

  import keypad_pkg::*;

  localparam int                DIV_W      = $clog2(SCAN_DIV);
  localparam int                CNT_W      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE   = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [2:0]        REARM_DONE = 3'(NUM_ROWS);

  logic [3:0]       col_s;
  logic [DIV_W-1:0] div;
  logic             sample;
  state_t           state, state_nx;
  logic [1:0]       row, row_nx;
  logic [1:0]       col_lat, col_lat_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic             armed, armed_nx;
  logic [2:0]       rearm, rearm_nx, rearm_inc;
  logic             any_low;
  logic             accept;
  logic [3:0]       accept_code;

  keypad_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d_n   (col_n),
    .q_n   (col_s)
  );

  assign sample      = (div == DIV_LAST);
  assign any_low     = (col_s != 4'hF);
  assign cnt_inc     = cnt + 1'b1;
  assign rearm_inc   = rearm + 3'd1;
  assign row_n       = ~(4'b0001 << row);
  assign accept_code = KEYMAP[row][col_lat_nx];

  // Row-period divider; its terminal count is the only column sample point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (sample) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_SCAN;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. After reset the scanner stays disarmed until a full
  // row rotation reads idle, so a key held through reset is never reported.
  always_comb begin
    state_nx   = state;
    row_nx     = row;
    col_lat_nx = col_lat;
    cnt_nx     = cnt;
    armed_nx   = armed;
    rearm_nx   = rearm;
    accept     = 1'b0;
    if (sample) begin
      case (state)
        ST_SCAN: begin
          if (!armed) begin
            row_nx = row + 2'd1;
            if (any_low) begin
              rearm_nx = 3'd0;
            end else begin
              rearm_nx = rearm_inc;
              if (rearm_inc == REARM_DONE) armed_nx = 1'b1;
            end
          end else if (any_low) begin
            col_lat_nx = lowest_low(col_s);
            if (CNT_DONE == CNT_W'(1)) begin
              accept   = 1'b1;
              state_nx = ST_RELEASE;
              cnt_nx   = '0;
            end else begin
              state_nx = ST_DEBOUNCE;
              cnt_nx   = CNT_W'(1);
            end
          end else begin
            row_nx = row + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (!col_s[col_lat]) begin
            cnt_nx = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              accept   = 1'b1;
              state_nx = ST_RELEASE;
              cnt_nx   = '0;
            end
          end else begin
            state_nx = ST_SCAN;
            cnt_nx   = '0;
            row_nx   = row + 2'd1;
          end
        end
        ST_RELEASE: begin
          if (any_low) begin
            cnt_nx = '0;
          end else if (cnt_inc == CNT_DONE) begin
            state_nx = ST_SCAN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        default: begin
          state_nx = ST_SCAN;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Scan datapath: current row, latched column, debounce and re-arm counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row     <= 2'd0;
      col_lat <= 2'd0;
      cnt     <= '0;
      armed   <= 1'b0;
      rearm   <= 3'd0;
    end else begin
      row     <= row_nx;
      col_lat <= col_lat_nx;
      cnt     <= cnt_nx;
      armed   <= armed_nx;
      rearm   <= rearm_nx;
    end
  end

  // Accepted-key outputs; clear wins over a coincident shift of value/count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
      value       <= 32'h0;
      digit_count <= 4'd0;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= accept_code;
      if (clear) begin
        value       <= 32'h0;
        digit_count <= 4'd0;
      end else if (accept) begin
        value <= {value[27:0], accept_code};
        if (digit_count < 4'd8) digit_count <= digit_count + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles per row period; legal range is SCAN_DIV >= 4.
REQ-002 Parameter DEBOUNCE_SCANS, default 4, consecutive sample points required to accept a press or a release; legal range is >= 1.
REQ-003 Port clk, input, 1, sole clock; all logic is rising-edge.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port col_n, input, 4, keypad column lines: active-low, externally pulled up, asynchronous to clk.
REQ-006 Port clear, input, 1, synchronous clear of value and digit_count.
REQ-007 Port row_n, output, 4, keypad row drive: active-low, exactly one bit low at all times.
REQ-008 Port key_valid, output, 1, one-cycle pulse when a key is accepted.
REQ-009 Port key_code, output, 4, hex code of the last accepted key; held between pulses.
REQ-010 Port value, output, 32, shift register of entered digits; the newest digit is in [3:0].
REQ-011 Port digit_count, output, 4, number of digits entered since clear, saturating at 8.

Function
REQ-012 col_n SHALL pass through a 2-flop synchronizer; all decisions use the synchronized copy.
REQ-013 A divider SHALL count 0..SCAN_DIV-1; its terminal cycle is the sample point.
REQ-014 In SCAN, row SHALL advance at each sample point: row 0->1->2->3->0, with row_n = ~(1<<row).
REQ-015 Columns SHALL be sampled only at sample points.
REQ-016 If several columns are low at once, the lowest column index SHALL win.
REQ-017 FSM states SHALL be SCAN, DEBOUNCE and RELEASE.
REQ-018 SCAN->DEBOUNCE on a sample with any column low: latch row and column, freeze row advance, set the debounce count to 1.
REQ-019 DEBOUNCE, sample with the latched column still low: increment the count.
REQ-020 DEBOUNCE, count reaches DEBOUNCE_SCANS: accept the key and go to RELEASE.
REQ-021 DEBOUNCE, sample with the latched column high: go back to SCAN, and row advances at that sample.
REQ-022 With DEBOUNCE_SCANS = 1, the key SHALL be accepted at the SCAN sample itself, moving SCAN->RELEASE.
REQ-023 On accept, key_valid SHALL be 1 for exactly the next cycle, and key_code SHALL update in the same cycle.
REQ-024 On accept, value SHALL become {value[27:0], code} and digit_count SHALL become min(digit_count+1, 8), both in the same cycle as key_valid.
REQ-025 RELEASE SHALL hold the row and go to SCAN after DEBOUNCE_SCANS consecutive samples with all columns high; any low sample restarts that count.
REQ-026 Keymap (row, col0..3): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = E(*) 0 F(#) D.
REQ-027 Key repeat is prohibited: a held key produces exactly one key_valid.
REQ-028 When clear coincides with an accept, value and digit_count SHALL be 0, while key_valid and key_code still update.
REQ-029 clear SHALL NOT affect the FSM, row or divider.

Reset
REQ-030 reset SHALL asynchronously force: state SCAN, divider 0, row 0 (row_n = 4'b1110), synchronizer flops 4'b1111, debounce count 0.
REQ-031 reset SHALL also force key_valid 0, key_code 0, value 0 and digit_count 0.
REQ-032 Reset asserted mid-DEBOUNCE or mid-RELEASE SHALL discard the pending key; no key_valid follows deassertion.

Structure
REQ-033 Package keypad_pkg SHALL hold the FSM state enum, the 4x4 keymap constant table and the row count constant.
REQ-034 Sub-module keypad_sync (4-bit, 2-flop, reset to all ones) SHALL implement the synchronizer; everything else lives in keypad_entry.

Verification (bench: SCAN_DIV=4, DEBOUNCE_SCANS=2)
REQ-035 Reset then idle with col_n=4'hF -> row_n cycles E,D,B,7 changing every 4 clk; key_valid never asserts.
REQ-036 Hold col_n[1] low while row_n=4'hD for 3 sample periods -> exactly one key_valid, key_code=4'h5, value=32'h5, digit_count=1.
REQ-037 Enter keys 1,2,3,A,4,5,6,B,7 with full releases -> value=32'h23A456B7, digit_count=8.
REQ-038 Low pulse on col_n[0] covering only 1 sample point -> no key_valid, and FSM back in SCAN.
REQ-039 Assert clear in the same cycle as the accept of key 9 -> key_valid=1, key_code=4'h9, value=0, digit_count=0.
REQ-040 Assert reset during RELEASE while a key is held -> all outputs at reset values; after deassertion no key_valid until the key is released and pressed again.
